sar_result_averager: RTL and testbench

Downstream consumer of the 4-bit SAR comparison/successive-approximation stage. It tracks conversion boundaries with its own phase counter and captures the converter's final code (adc_out) once per conversion. It accumulates 2^AVG_LOG2 conversions and presents the truncated mean on a valid/ready output port with a sticky overrun flag. It sits between the SAR logic and the digital consumer (register bank / serializer).

---
 rtl/sar_result_averager.sv | 109 ++++++++++
 tb/tb_sar_result_averager.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sar_result_averager.sv
// Averages 2^AVG_LOG2 SAR conversion results and presents the floored mean
// on a valid/ready port with a sticky overrun flag.
module sar_result_averager #(
   parameter int ADC_BITS    = 4,
   parameter int CONV_CYCLES = 5,
   parameter int AVG_LOG2    = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                enable,
   input  logic [ADC_BITS-1:0] adc_out,
   output logic                sample_strobe,
   output logic [ADC_BITS-1:0] avg_data,
   output logic                avg_valid,
   input  logic                avg_ready,
   output logic                overrun,
   input  logic                clear_overrun
);

   localparam int PH_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACC_W = ADC_BITS + AVG_LOG2;
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              r_state;
   logic [PH_W-1:0]     r_phase;
   logic [CNT_W-1:0]    r_count;
   logic [ACC_W-1:0]    r_acc;
   logic                r_strobe;
   logic [ADC_BITS-1:0] r_data;
   logic                r_valid;
   logic                r_overrun;

   logic                w_capture;
   logic                w_last;
   logic [ACC_W-1:0]    w_sum;
   logic [ADC_BITS-1:0] w_result;

   assign w_capture = enable && (r_phase == PH_LAST);
   assign w_last    = w_capture && (r_count == CNT_LAST);
   assign w_sum     = r_acc + ACC_W'(adc_out);
   assign w_result  = w_sum[ACC_W-1:AVG_LOG2];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_phase   <= '0;
         r_count   <= '0;
         r_acc     <= '0;
         r_strobe  <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_strobe <= w_capture;

         // Leaving RUN discards any partial average and realigns the phase.
         case (r_state)
            IDLE: if (enable) r_state <= RUN;
            RUN: begin
               if (!enable) begin
                  r_state <= IDLE;
                  r_phase <= '0;
                  r_count <= '0;
                  r_acc   <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (enable) begin
            if (w_capture) begin
               r_phase <= '0;
               if (w_last) begin
                  r_count <= '0;
                  r_acc   <= '0;
               end else begin
                  r_count <= r_count + CNT_W'(1);
                  r_acc   <= w_sum;
               end
            end else begin
               r_phase <= r_phase + PH_W'(1);
            end
         end

         // A fresh result may replace one being accepted on the same edge.
         if (w_last && (!r_valid || avg_ready)) begin
            r_data  <= w_result;
            r_valid <= 1'b1;
         end else if (r_valid && avg_ready) begin
            r_valid <= 1'b0;
         end

         if (w_last && r_valid && !avg_ready)
            r_overrun <= 1'b1;
         else if (clear_overrun)
            r_overrun <= 1'b0;
      end
   end

   assign sample_strobe = r_strobe;
   assign avg_data      = r_data;
   assign avg_valid     = r_valid;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_sar_result_averager.sv
// Directed bench for sar_result_averager: per-conversion vector table plus
// hand sequences for abort, idle handshake and asynchronous reset.
module tb_sar_result_averager;

   logic       clk = 1'b0;
   logic       rstn;
   logic       enable;
   logic [3:0] adc_out;
   logic       sample_strobe;
   logic [3:0] avg_data;
   logic       avg_valid;
   logic       avg_ready;
   logic       overrun;
   logic       clear_overrun;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic [3:0] adc;
      logic       rdy;
      logic       rdyCap;
      logic       clr;
      logic       expValid;
      logic [3:0] expData;
      logic       expOvr;
   } vec_t;

   vec_t vecs [24];

   sar_result_averager dut (
      .clk           (clk),
      .rstn          (rstn),
      .enable        (enable),
      .adc_out       (adc_out),
      .sample_strobe (sample_strobe),
      .avg_data      (avg_data),
      .avg_valid     (avg_valid),
      .avg_ready     (avg_ready),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // One full conversion (CONV_CYCLES=5 edges) with checks after edges 4 and 5.
   task automatic applyStimulus(input string name, input logic [3:0] adc, input logic rdy,
                                input logic rdyCap, input logic clr, input logic expValid,
                                input logic [3:0] expData, input logic expOvr);
      for (int k = 1; k <= 5; k++) begin
         enable        = 1'b1;
         adc_out       = adc;
         avg_ready     = (k == 5) ? rdyCap : rdy;
         clear_overrun = (k == 1) ? clr : 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (k == 4) checkOutput({name, " strobe_pre"}, int'(sample_strobe), 0);
      end
      checkOutput({name, " strobe"}, int'(sample_strobe), 1);
      checkOutput({name, " valid"}, int'(avg_valid), int'(expValid));
      checkOutput({name, " data"}, int'(avg_data), int'(expData));
      checkOutput({name, " overrun"}, int'(overrun), int'(expOvr));
   endtask

   task automatic idleEdges(input int n, input logic en, input logic rdy);
      for (int k = 0; k < n; k++) begin
         enable        = en;
         avg_ready     = rdy;
         clear_overrun = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      //           adc    rdy   rdyCap clr   expV  expD   expO
      vecs[0]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[1]  = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[2]  = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[3]  = '{4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 4'd6,  1'b0};
      vecs[4]  = '{4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  1'b0};
      vecs[5]  = '{4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  1'b0};
      vecs[6]  = '{4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  1'b0};
      vecs[7]  = '{4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  1'b0};
      vecs[8]  = '{4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0};
      vecs[9]  = '{4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0};
      vecs[10] = '{4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0};
      vecs[11] = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0};
      vecs[12] = '{4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
      vecs[13] = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
      vecs[14] = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
      vecs[15] = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[16] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[17] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[18] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[19] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b1};
      vecs[20] = '{4'd8,  1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0};
      vecs[21] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[22] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0};
      vecs[23] = '{4'd8,  1'b0, 1'b1, 1'b0, 1'b1, 4'd8,  1'b0};

      rstn          = 1'b0;
      enable        = 1'b0;
      adc_out       = 4'd0;
      avg_ready     = 1'b0;
      clear_overrun = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset valid", int'(avg_valid), 0);
      checkOutput("reset data", int'(avg_data), 0);
      checkOutput("reset strobe", int'(sample_strobe), 0);
      checkOutput("reset overrun", int'(overrun), 0);
      rstn = 1'b1;

      for (int i = 0; i < 24; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].adc, vecs[i].rdy, vecs[i].rdyCap,
                       vecs[i].clr, vecs[i].expValid, vecs[i].expData, vecs[i].expOvr);
      end

      // Acceptance while idle; this edge also follows a capture, so the strobe must be gone.
      idleEdges(1, 1'b0, 1'b1);
      checkOutput("idle accept valid", int'(avg_valid), 0);
      checkOutput("idle accept data", int'(avg_data), 8);
      checkOutput("strobe one cycle", int'(sample_strobe), 0);

      // Abort after two captures plus two edges of the third conversion.
      applyStimulus("abort c1", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
      applyStimulus("abort c2", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
      adc_out = 4'd10;
      idleEdges(2, 1'b1, 1'b0);
      idleEdges(1, 1'b0, 1'b0);
      checkOutput("abort hold data", int'(avg_data), 8);
      applyStimulus("reen c1", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
      applyStimulus("reen c2", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
      applyStimulus("reen c3", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
      applyStimulus("reen c4", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);

      // Build up a dropped result, then reset asynchronously inside conversion 3.
      applyStimulus("pre c1", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
      applyStimulus("pre c2", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
      applyStimulus("pre c3", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
      applyStimulus("pre c4", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
      applyStimulus("pre c5", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
      applyStimulus("pre c6", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
      adc_out = 4'd5;
      idleEdges(2, 1'b1, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("async valid", int'(avg_valid), 0);
      checkOutput("async data", int'(avg_data), 0);
      checkOutput("async overrun", int'(overrun), 0);
      checkOutput("async strobe", int'(sample_strobe), 0);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus("post c1", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus("post c2", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus("post c3", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus("post c4", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
